// File: rtl/arm_dp_pkg.sv
// Shared ARM data-processing definitions: condition codes, NZCV bit positions,
// and the control half of a commit-queue entry.
package arm_dp_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] REG_PC = 4'd15;

    // Result data (F) is kept alongside this struct so its width can follow DW.
    typedef struct packed {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       s;
        logic       wr_rd;
        logic [3:0] rd;
    } dp_ctrl_t;

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluator against an NZCV flag set; purely combinational.
module arm_cond_check
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_flag_commit.sv
// Commit stage after the DP ALU: 2-entry head/skid queue, condition check,
// NZCV update, register-file write and PC-write flush.
module dp_flag_commit
    import arm_dp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_F,
    input  logic [3:0]       in_NZCV,
    input  logic [3:0]       in_cond,
    input  logic             in_S,
    input  logic             in_wr_rd,
    input  logic [3:0]       in_rd,
    input  logic             out_ready,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic             pc_wr,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    logic             head_valid, head_valid_n;
    logic             skid_valid, skid_valid_n;
    logic             in_ready_q, in_ready_n;
    dp_ctrl_t         head_c, head_c_n, skid_c, skid_c_n, in_c;
    logic [DW-1:0]    head_f, head_f_n, skid_f, skid_f_n;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] retire_q, skip_q;
    logic             pass, commit, accept;

    assign in_c = '{nzcv: in_NZCV, cond: in_cond, s: in_S, wr_rd: in_wr_rd, rd: in_rd};

    arm_cond_check u_cond (
        .cond  (head_c.cond),
        .flags (flags_q),
        .pass  (pass)
    );

    // Gating with rst keeps a queued head from writing in the reset cycle.
    assign commit   = head_valid && out_ready && !rst;
    assign rf_we    = commit && pass && head_c.wr_rd;
    assign rf_waddr = rf_we ? head_c.rd : 4'd0;
    assign rf_wdata = rf_we ? head_f : '0;
    assign pc_wr    = rf_we && (head_c.rd == REG_PC);
    assign in_ready = in_ready_q && !rst;
    assign accept   = in_valid && in_ready;

    assign flags      = flags_q;
    assign retire_cnt = retire_q;
    assign skip_cnt   = skip_q;

    always_comb begin
        head_valid_n = head_valid;
        skid_valid_n = skid_valid;
        head_c_n     = head_c;
        head_f_n     = head_f;
        skid_c_n     = skid_c;
        skid_f_n     = skid_f;
        if (pc_wr) begin
            // Flush: younger work (skid and any same-cycle accept) is discarded.
            head_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (commit) begin
            if (skid_valid) begin
                head_c_n     = skid_c;
                head_f_n     = skid_f;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                head_c_n = in_c;
                head_f_n = in_F;
            end else begin
                head_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!head_valid) begin
                head_c_n     = in_c;
                head_f_n     = in_F;
                head_valid_n = 1'b1;
            end else begin
                skid_c_n     = in_c;
                skid_f_n     = in_F;
                skid_valid_n = 1'b1;
            end
        end
        in_ready_n = !pc_wr && !skid_valid_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
            flags_q    <= 4'b0000;
            retire_q   <= '0;
            skip_q     <= '0;
        end else begin
            head_valid <= head_valid_n;
            skid_valid <= skid_valid_n;
            in_ready_q <= in_ready_n;
            if (commit) begin
                if (pass) begin
                    retire_q <= retire_q + 1'b1;
                    if (head_c.s) flags_q <= head_c.nzcv;
                end else begin
                    skip_q <= skip_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        head_c <= head_c_n;
        head_f <= head_f_n;
        skid_c <= skid_c_n;
        skid_f <= skid_f_n;
    end

endmodule

// File: tb/tb_dp_flag_commit.sv
// Directed bench for dp_flag_commit: expected register writes go into a
// scoreboard queue; a monitor branch pops and compares on every rf_we.
module tb_dp_flag_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_F;
    logic [3:0]  in_NZCV;
    logic [3:0]  in_cond;
    logic        in_S;
    logic        in_wr_rd;
    logic [3:0]  in_rd;
    logic        out_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_wr;
    logic [3:0]  flags;
    logic [15:0] retire_cnt;
    logic [15:0] skip_cnt;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic        pc;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    dp_flag_commit #(.DW(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_F       (in_F),
        .in_NZCV    (in_NZCV),
        .in_cond    (in_cond),
        .in_S       (in_S),
        .in_wr_rd   (in_wr_rd),
        .in_rd      (in_rd),
        .out_ready  (out_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pc_wr      (pc_wr),
        .flags      (flags),
        .retire_cnt (retire_cnt),
        .skip_cnt   (skip_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] f, input logic [3:0] nzcv, input logic [3:0] cond,
                         input logic s, input logic wr, input logic [3:0] rd);
        in_F     = f;
        in_NZCV  = nzcv;
        in_cond  = cond;
        in_S     = s;
        in_wr_rd = wr;
        in_rd    = rd;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] f, input logic [3:0] nzcv, input logic [3:0] cond,
                        input logic s, input logic wr, input logic [3:0] rd,
                        input bit exp_w, input bit exp_pc);
        int n;
        wr_t e;
        drive(f, nzcv, cond, s, wr, rd);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for rd=%0d", rd);
            in_valid = 1'b0;
            return;
        end
        if (exp_w) begin
            e.a  = rd;
            e.d  = f;
            e.pc = exp_pc;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_F      = '0;
        in_NZCV   = '0;
        in_cond   = '0;
        in_S      = 1'b0;
        in_wr_rd  = 1'b0;
        in_rd     = '0;
        fork
            begin : monitor
                wr_t e;
                forever begin
                    @(negedge clk);
                    #4;
                    if (pc_wr && !rf_we) check("pc_wr_without_we", 32'(pc_wr), 32'd0);
                    if (rf_we) begin
                        if (sb.size() == 0) begin
                            check("unexpected_write_addr", 32'(rf_waddr), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            check("wr_addr", 32'(rf_waddr), 32'(e.a));
                            check("wr_data", rf_wdata, e.d);
                            check("wr_pc", 32'(pc_wr), 32'(e.pc));
                        end
                    end
                end
            end
            begin : stim
                repeat (3) @(negedge clk);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_rf_we", 32'(rf_we), 32'd0);
                check("rst_pc_wr", 32'(pc_wr), 32'd0);
                check("rst_flags", 32'(flags), 32'd0);
                check("rst_retire", 32'(retire_cnt), 32'd0);
                check("rst_skip", 32'(skip_cnt), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_in_ready", 32'(in_ready), 32'd1);

                // ADDS R1 -> 0, Z set
                send(32'h0, 4'b0100, 4'b1110, 1'b1, 1'b1, 4'd1, 1, 0);
                @(negedge clk);
                check("adds_flags", 32'(flags), 32'h4);
                check("adds_retire", 32'(retire_cnt), 32'd1);

                // CMP then MOVEQ R2,#5 back to back
                send(32'hDEAD, 4'b0110, 4'b1110, 1'b1, 1'b0, 4'd0, 0, 0);
                send(32'h5, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd2, 1, 0);
                @(negedge clk);
                check("cmp_flags", 32'(flags), 32'h6);
                check("moveq_retire", 32'(retire_cnt), 32'd3);

                // MOVNE R3 fails with Z=1
                send(32'h7, 4'b1000, 4'b0001, 1'b1, 1'b1, 4'd3, 0, 0);
                @(negedge clk);
                check("movne_flags", 32'(flags), 32'h6);
                check("movne_skip", 32'(skip_cnt), 32'd1);
                check("movne_retire", 32'(retire_cnt), 32'd3);

                // Stall: two held, third refused
                out_ready = 1'b0;
                send(32'h11, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd5, 1, 0);
                send(32'h22, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd6, 1, 0);
                check("skid_full_ready", 32'(in_ready), 32'd0);
                drive(32'h33, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd7);
                @(negedge clk);
                in_valid = 1'b0;
                @(negedge clk);
                check("stall_retire", 32'(retire_cnt), 32'd3);
                check("stall_flags", 32'(flags), 32'h6);
                out_ready = 1'b1;
                repeat (3) @(negedge clk);
                check("release_retire", 32'(retire_cnt), 32'd5);
                check("release_ready", 32'(in_ready), 32'd1);

                // MOV PC,#0x100 flushes the following ADD R4
                send(32'h100, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd15, 1, 1);
                send(32'h44, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd4, 0, 0);
                check("flush_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
                check("flush_ready_back", 32'(in_ready), 32'd1);
                check("flush_retire", 32'(retire_cnt), 32'd6);
                check("flush_skip", 32'(skip_cnt), 32'd1);

                // NV condition with S=1
                send(32'h88, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'd8, 0, 0);
                @(negedge clk);
                check("nv_flags", 32'(flags), 32'h6);
                check("nv_skip", 32'(skip_cnt), 32'd2);
                check("nv_retire", 32'(retire_cnt), 32'd6);

                // Reset with two queued entries
                out_ready = 1'b0;
                send(32'h99, 4'b1010, 4'b1110, 1'b1, 1'b1, 4'd9, 0, 0);
                send(32'hAA, 4'b1010, 4'b1110, 1'b1, 1'b1, 4'd10, 0, 0);
                rst       = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) @(negedge clk);
                check("rst2_flags", 32'(flags), 32'd0);
                check("rst2_retire", 32'(retire_cnt), 32'd0);
                check("rst2_skip", 32'(skip_cnt), 32'd0);
                check("sb_empty", 32'(sb.size()), 32'd0);

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end

endmodule
